// File: rtl/recursion_pkg.sv
// Shared definitions for the recursion sequencer: FSM state encoding and
// the start-strobe length. The FAULT state exists only when SEQ_TIMEOUT_EN
// is defined.
package recursion_pkg;

  // F_ST is held this many cycles so a registered edge detector downstream
  // always sees a clean 0->1 transition.
  localparam int LAUNCH_LEN = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
`ifdef SEQ_TIMEOUT_EN
    ,
    FAULT     = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/recursion_sequencer.sv
// Recursion sequencer: hands one (A, B) request to the composition block,
// strobes F_ST, waits for the block's busy/done handshake on F_RD and
// returns F_RES on RESULT with a one-cycle ACK.
// Optional macro SEQ_TIMEOUT_EN: bounds the waits with a TMO_CYCLES counter
// and parks in a sticky FAULT state (ERR=1) until reset.
module recursion_sequencer
  import recursion_pkg::*;
#(
  parameter int BW         = 16,
  parameter int TMO_CYCLES = 1023
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  output logic          BUSY,
  output logic          ACK,
  output logic [BW-1:0] RESULT,
  output logic          ERR,
  output logic          F_ST,
  output logic [BW-1:0] F_IN0,
  output logic [BW-1:0] F_IN1,
  input  logic          F_RD,
  input  logic [BW-1:0] F_RES
);

  localparam int LCNT_W = $clog2(LAUNCH_LEN + 1);

  state_t              state, state_nx;
  logic [LCNT_W-1:0]   lcnt;
  logic                seen_low;
  logic                accept;
  logic                capture;
  logic                tmo_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TMO_CYCLES - 1));

  // Wait-time counter: restarts on every state entry, runs only while waiting.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                tmo_cnt <= '0;
    else if (!waiting || state_nx != state) tmo_cnt <= '0;
    else                                     tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nx = state;
    BUSY     = (state != IDLE);
    ACK      = 1'b0;
    F_ST     = 1'b0;
    ERR      = 1'b0;
    case (state)
      IDLE:      if (REQ && F_RD) state_nx = LAUNCH;
      LAUNCH: begin
        F_ST = 1'b1;
        // A drop of F_RD already seen while strobing means the block has
        // started; skip straight to waiting for done.
        if (lcnt == LCNT_W'(LAUNCH_LEN - 1))
          state_nx = (seen_low || !F_RD) ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!F_RD)        state_nx = WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_hit) state_nx = FAULT;
`endif
      end
      WAIT_DONE: begin
        if (F_RD)         state_nx = DONE;
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_hit) state_nx = FAULT;
`endif
      end
      DONE: begin
        ACK      = 1'b1;
        state_nx = IDLE;
      end
`ifdef SEQ_TIMEOUT_EN
      FAULT:     ERR = 1'b1;
`endif
      default:   state_nx = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && REQ && F_RD;
  assign capture = (state == WAIT_DONE) && F_RD;

  // Strobe-length counter and "block went busy during launch" flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lcnt     <= '0;
      seen_low <= 1'b0;
    end else begin
      lcnt <= (state == LAUNCH) ? lcnt + 1'b1 : '0;
      if (state == IDLE)                seen_low <= 1'b0;
      else if (state == LAUNCH && !F_RD) seen_low <= 1'b1;
    end
  end

  // Operand latch on acceptance and result capture on done; operands stay
  // frozen for the whole transaction.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      F_IN0  <= '0;
      F_IN1  <= '0;
      RESULT <= '0;
    end else begin
      if (accept) begin
        F_IN0 <= A;
        F_IN1 <= B;
      end
      if (capture) RESULT <= F_RES;
    end
  end

  // tmo_hit only steers the FSM when the timeout is built in.
  logic unused_ok;
  assign unused_ok = tmo_hit;

endmodule
